uart_rx: RTL and testbench

//   Asynchronous serial receiver, 8N1 by default. Front end of the UART game path.

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop synchronizer, 2-of-3 majority vote at mid-bit,
// start-bit glitch rejection, one-cycle rx_valid / rx_ferr strobes.
module uart_rx #(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ferr,
    output logic                 rx_busy
);

    localparam int N      = CLK_HZ / BAUD;
    localparam int H      = N / 2;
    localparam int TICK_W = $clog2(N);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    if (N < 4) begin : g_n_check
        $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           hist_q, hist_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    logic                 rx_s;
    logic                 m;
    logic                 tick_at_n;
    logic [DATA_BITS:0]   shift_ext;

    assign rx_s      = sync_q[1];
    assign m         = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    assign tick_at_n = (tick_q == TICK_W'(N - 1));
    // New bit enters at the MSB so that after DATA_BITS shifts bit 0 holds the first bit sent.
    assign shift_ext = {m, shift_q};

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], RX};
        hist_d  = {hist_q[0], rx_s};
        tick_d  = tick_at_n ? '0 : tick_q + TICK_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (tick_q == TICK_W'(H - 1)) begin
                    tick_d  = '0;
                    state_d = m ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_at_n) begin
                    shift_d = shift_ext[DATA_BITS:1];
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (tick_at_n) begin
                    if (m) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            // A held-low line stays here so it cannot retrigger a frame.
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '1;
            hist_q  <= '1;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a line-level frame sender feeds an event scoreboard (expected strobe
// cycle, kind, byte); one negedge process compares all strobes and rx_data every cycle.
module tb_uart_rx;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 115200;
    localparam int DB     = 8;
    localparam int N      = CLK_HZ / BAUD;
    localparam int H      = N / 2;
    // From the cycle the line falls: 2 synchronizer cycles give t, strobe at t+H+(DB+1)*N+1.
    localparam int LAT    = 2 + H + (DB + 1) * N + 1;
    localparam real PNOM  = real'(CLK_HZ) / real'(BAUD);

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [7:0] d;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RX  = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_ferr, rx_busy;

    int   cyc = 0;
    logic rst_smp = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;
    int   nferr = 0;
    int   exp_nvalid = 0;
    int   exp_nferr = 0;
    ev_t  q[$];
    logic [7:0] mdata = 8'h00;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .RX(RX),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= rst;
    end

    // Per-cycle comparison against the scoreboard.
    always @(negedge clk) begin
        ev_t  e;
        logic ev, ef;
        if (chk_en) begin
            ev = 1'b0;
            ef = 1'b0;
            if (rst_smp) begin
                q.delete();
                mdata = 8'h00;
                checks++;
                if (rx_valid !== 1'b0 || rx_ferr !== 1'b0 || rx_busy !== 1'b0 || rx_data !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d actual v=%b f=%b busy=%b data=%h required all 0",
                             cyc, rx_valid, rx_ferr, rx_busy, rx_data);
                end
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event expected at cyc=%0d data=%h ferr=%b", e.cyc, e.d, e.ferr);
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    ev = !e.ferr;
                    ef = e.ferr;
                    if (ev) mdata = e.d;
                end
                checks++;
                if (rx_valid !== ev || rx_ferr !== ef || rx_data !== mdata) begin
                    errors++;
                    $display("FAIL cycle_check cyc=%0d actual v=%b f=%b data=%h required v=%b f=%b data=%h",
                             cyc, rx_valid, rx_ferr, rx_data, ev, ef, mdata);
                end
            end
            if (rx_valid === 1'b1) nvalid++;
            if (rx_ferr === 1'b1) nferr++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge on which the next frame may start.
    task automatic send_frame(input logic [7:0] d, input real p, input bit stop_v, input bit spike);
        bit [9:0] fr;
        int len, k, f;
        fr  = {stop_v, d, 1'b0};
        len = $rtoi(10.0 * p);
        f   = cyc;
        q.push_back('{f + LAT, !stop_v, d});
        if (stop_v) exp_nvalid++;
        else exp_nferr++;
        for (int c = 0; c < len; c++) begin
            k = $rtoi(real'(c) / p);
            if (k > 9) k = 9;
            RX = fr[k];
            if (spike && k >= 1 && k <= 8 && c == k * N + H) RX = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int f, base;
        logic [7:0] d;
        real fac;
        bit sv;
        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        idle(10);

        // Two nominal frames.
        send_frame(8'h55, PNOM, 1'b1, 1'b0);
        check("t1_data_55", {24'd0, rx_data}, 32'h55);
        idle(2 * N);
        send_frame(8'hA3, PNOM, 1'b1, 1'b0);
        check("t1_data_a3", {24'd0, rx_data}, 32'hA3);
        check("t1_nvalid", nvalid, 32'd2);
        idle(2 * N);

        // Start-bit glitch: 20 low cycles, rejected at mid-start.
        f  = cyc;
        RX = 1'b0;
        repeat (20) @(negedge clk);
        RX = 1'b1;
        wait_until(f + 10);
        check("t2_busy_mid", {31'd0, rx_busy}, 32'd1);
        wait_until(f + 54);
        check("t2_busy_before_sample", {31'd0, rx_busy}, 32'd1);
        wait_until(f + 55);
        check("t2_busy_after_sample", {31'd0, rx_busy}, 32'd0);
        idle(2 * N);
        check("t2_no_strobe", nvalid + nferr, 32'd2);

        // Framing error then long break, then recovery.
        send_frame(8'h3C, PNOM, 1'b0, 1'b0);
        RX = 1'b0;
        repeat (2000) @(negedge clk);
        check("t3_nferr", nferr, 32'd1);
        check("t3_data_held", {24'd0, rx_data}, 32'hA3);
        check("t3_busy_break", {31'd0, rx_busy}, 32'd1);
        idle(3 * N);
        send_frame(8'h0D, PNOM, 1'b1, 1'b0);
        check("t3_data_0d", {24'd0, rx_data}, 32'h0D);
        check("t3_nferr_once", nferr, 32'd1);
        idle(2 * N);

        // Back-to-back frames, then +/-2% baud.
        base = nvalid;
        send_frame(8'h00, PNOM, 1'b1, 1'b0);
        send_frame(8'hFF, PNOM, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_frame(8'($urandom), PNOM / 1.02, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_frame(8'($urandom), PNOM / 0.98, 1'b1, 1'b0);
        idle(2 * N);
        check("t4_nvalid_22", nvalid - base, 32'd22);

        // One-cycle low spike at each data-bit sample point.
        send_frame(8'hFF, PNOM, 1'b1, 1'b1);
        idle(2 * N);
        check("t5_spike_ff", {24'd0, rx_data}, 32'hFF);

        // Reset in the middle of data bit 4 of 0xF5 (bits 4..7 and stop are high).
        base = nvalid;
        fork
            send_frame(8'hF5, PNOM, 1'b1, 1'b0);
            begin
                repeat (5 * N + H) @(negedge clk);
                check("t6_busy_pre_rst", {31'd0, rx_busy}, 32'd1);
                rst = 1'b1;
                @(negedge clk);
                check("t6_data_rst", {24'd0, rx_data}, 32'd0);
                rst = 1'b0;
            end
        join
        exp_nvalid--;
        idle(20 * N);
        check("t6_no_strobe", nvalid - base, 32'd0);
        send_frame(8'h7E, PNOM, 1'b1, 1'b0);
        idle(2 * N);
        check("t6_data_7e", {24'd0, rx_data}, 32'h7E);

        // Random bytes, baud within +/-1.5%, occasional bad stop bit.
        for (int i = 0; i < 15; i++) begin
            d   = 8'($urandom);
            fac = 1.0 + real'(int'($urandom_range(0, 30)) - 15) / 1000.0;
            sv  = ($urandom_range(0, 4) != 0);
            send_frame(d, PNOM / fac, sv, 1'b0);
            idle(sv ? int'($urandom_range(0, 30)) : int'($urandom_range(2, 30)));
        end
        idle(2 * N);

        check("end_queue_empty", q.size(), 32'd0);
        check("end_nvalid", nvalid, exp_nvalid);
        check("end_nferr", nferr, exp_nferr);
        check("end_idle", {31'd0, rx_busy}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 95000);
        errors++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
